// File: rtl/divlog_pkg.sv
// Shared types and record layout helpers for the divergence logger.
//   state_t      : logger FSM states (IDLE, ARMED, FLUSH)
//   CH_IDX_W     : width of the channel-index field in a log record
//   CYCLE_NUM_W  : width of the free-running bench cycle count
//   LOAD_CNT_W   : width of a per-cycle event count across up to 256 channels
//   log_width()  : record width {cycle, ch_idx, xor}
//   rec_*_lsb()  : field offsets inside a record
package divlog_pkg;

   localparam int unsigned CH_IDX_W    = 8;
   localparam int unsigned CYCLE_NUM_W = 48;
   localparam int unsigned LOAD_CNT_W  = CH_IDX_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FLUSH = 2'd2
   } state_t;

   function automatic int unsigned log_width(input int unsigned cyc_w, input int unsigned data_w);
      return cyc_w + CH_IDX_W + data_w;
   endfunction

   function automatic int unsigned rec_ch_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned rec_cyc_lsb(input int unsigned data_w);
      return data_w + CH_IDX_W;
   endfunction

endpackage

// File: rtl/divlog_fifo.sv
// Synchronous first-word-fall-through FIFO for log records.
// Ports:
//   clock, rst   : rising-edge clock, synchronous active-high reset
//   clr          : synchronous flush (same effect as rst on pointers)
//   push/push_data: write request; accepted when not full or when popping the same cycle
//   pop          : read request; ignored when empty
//   head         : current head record (valid while !empty)
//   full, empty  : occupancy flags
module divlog_fifo
   import divlog_pkg::*;
#(
   parameter int unsigned WIDTH = 72,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array, no reset needed: contents are only observed through count.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/divergence_logger.sv
// Multi-channel golden-vs-injected comparator and mismatch logger.
// While armed and run is high, every channel's golden/injected pair is XOR-compared;
// a diverging channel is snapshotted into its slot, slots drain lowest-channel-first
// into a FWFT log FIFO, and records leave on a valid/ready stream.
// Optional build macro: DIVLOG_SUPPRESS_REPEAT_EN (skip mismatches repeating the
// channel's last-logged xor value).
// Ports:
//   clock, rst         : rising-edge clock, synchronous active-high reset
//   cycle_number       : free-running bench cycle count
//   run                : comparisons enabled while high; arms from IDLE, flushes when low
//   golden, injected   : packed channel data, channel 0 in the LSBs
//   log_valid/ready    : record stream handshake
//   log_data           : {cycle[CYC_W-1:0], ch_idx[7:0], xor[DATA_W-1:0]}, 0 when idle
//   first_div_*        : first divergence since arm (cycle and lowest channel)
//   mismatch_cnt       : captured records (saturating)
//   drop_cnt           : mismatches lost to a busy slot (saturating)
//   done               : one-cycle pulse when a flush completes
module divergence_logger
   import divlog_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned CYC_W      = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                             clock,
   input  logic                             rst,
   input  logic [CYCLE_NUM_W-1:0]           cycle_number,
   input  logic                             run,
   input  logic [NUM_CH*DATA_W-1:0]         golden,
   input  logic [NUM_CH*DATA_W-1:0]         injected,
   output logic                             log_valid,
   input  logic                             log_ready,
   output logic [CYC_W+CH_IDX_W+DATA_W-1:0] log_data,
   output logic                             first_div_valid,
   output logic [CYCLE_NUM_W-1:0]           first_div_cycle,
   output logic [CH_IDX_W-1:0]              first_div_ch,
   output logic [CNT_W-1:0]                 mismatch_cnt,
   output logic [CNT_W-1:0]                 drop_cnt,
   output logic                             done
);

   localparam int unsigned      LOG_W   = log_width(CYC_W, DATA_W);
   localparam int unsigned      SUM_W   = CNT_W + LOAD_CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic              full;
      logic [CYC_W-1:0]  cyc;
      logic [DATA_W-1:0] x;
   } slot_t;

   state_t                state;
   state_t                state_nxt;
   logic                  arm;
   logic                  done_nxt;

   slot_t                 slots [NUM_CH];
   logic [DATA_W-1:0]     x [NUM_CH];
   logic [NUM_CH-1:0]     mismatch;
   logic [NUM_CH-1:0]     capture;
   logic [NUM_CH-1:0]     load;
   logic [NUM_CH-1:0]     drop;
   logic [NUM_CH-1:0]     drain_sel;
   logic [NUM_CH-1:0]     drain_now;
   logic                  any_full;
   logic                  any_mismatch;
   logic [CH_IDX_W-1:0]   first_ch_c;

   logic [LOG_W-1:0]      drain_rec;
   logic [LOG_W-1:0]      fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;

   logic [LOAD_CNT_W-1:0] n_load;
   logic [LOAD_CNT_W-1:0] n_drop;
   logic [SUM_W-1:0]      mc_sum;
   logic [SUM_W-1:0]      dc_sum;
   logic [CNT_W-1:0]      mc_nxt;
   logic [CNT_W-1:0]      dc_nxt;

   // Per-channel compare, enabled only while armed and running.
   always_comb begin
      mismatch     = '0;
      any_mismatch = 1'b0;
      first_ch_c   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         x[c]        = golden[c*DATA_W +: DATA_W] ^ injected[c*DATA_W +: DATA_W];
         mismatch[c] = (state == ARMED) && run && (|x[c]);
         if (mismatch[c] && !any_mismatch) begin
            first_ch_c   = CH_IDX_W'(c);
            any_mismatch = 1'b1;
         end
      end
   end

`ifdef DIVLOG_SUPPRESS_REPEAT_EN
   logic [DATA_W-1:0] last_x [NUM_CH];

   // A repeat of the last-logged value is neither captured nor counted.
   always_comb begin
      capture = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         capture[c] = mismatch[c] && (x[c] != last_x[c]);
      end
   end

   // Last-logged value follows captures; a clean compare forgets it.
   always_ff @(posedge clock) begin
      if (rst || arm) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            last_x[c] <= '0;
         end
      end else if ((state == ARMED) && run) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (x[c] == '0) begin
               last_x[c] <= '0;
            end else if (load[c]) begin
               last_x[c] <= x[c];
            end
         end
      end
   end
`else
   assign capture = mismatch;
`endif

   // Fixed-priority drain select: lowest full slot wins while the FIFO has room.
   always_comb begin
      drain_sel = '0;
      any_full  = 1'b0;
      drain_rec = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (slots[c].full && !any_full) begin
            drain_sel[c] = 1'b1;
            any_full     = 1'b1;
            drain_rec    = {slots[c].cyc, CH_IDX_W'(c), slots[c].x};
         end
      end
      drain_now = fifo_full ? '0 : drain_sel;
   end

   // Slot load/drop decisions; a slot draining this cycle can reload without a drop.
   always_comb begin
      load   = '0;
      drop   = '0;
      n_load = '0;
      n_drop = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         load[c] = capture[c] && (!slots[c].full || drain_now[c]);
         drop[c] = capture[c] && slots[c].full && !drain_now[c];
         n_load  = n_load + LOAD_CNT_W'(load[c]);
         n_drop  = n_drop + LOAD_CNT_W'(drop[c]);
      end
   end

   // Saturating counter updates (several channels may count in one cycle).
   always_comb begin
      mc_sum = SUM_W'(mismatch_cnt) + SUM_W'(n_load);
      dc_sum = SUM_W'(drop_cnt) + SUM_W'(n_drop);
      mc_nxt = (mc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : mc_sum[CNT_W-1:0];
      dc_nxt = (dc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : dc_sum[CNT_W-1:0];
   end

   // FSM next state; arm clears session state, done marks the end of a flush.
   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_nxt = ARMED;
               arm       = 1'b1;
            end
         end
         ARMED: begin
            if (!run) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (!any_full && fifo_empty) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and done pulse.
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // Channel snapshot slots.
   always_ff @(posedge clock) begin
      if (rst || arm) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            slots[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (load[c]) begin
               slots[c] <= {1'b1, cycle_number[CYC_W-1:0], x[c]};
            end else if (drain_now[c]) begin
               slots[c].full <= 1'b0;
            end
         end
      end
   end

   // Statistics and first-divergence capture.
   always_ff @(posedge clock) begin
      if (rst || arm) begin
         mismatch_cnt    <= '0;
         drop_cnt        <= '0;
         first_div_valid <= 1'b0;
         first_div_cycle <= '0;
         first_div_ch    <= '0;
      end else begin
         mismatch_cnt <= mc_nxt;
         drop_cnt     <= dc_nxt;
         if (!first_div_valid && any_mismatch) begin
            first_div_valid <= 1'b1;
            first_div_cycle <= cycle_number;
            first_div_ch    <= first_ch_c;
         end
      end
   end

   divlog_fifo #(
      .WIDTH (LOG_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .rst       (rst),
      .clr       (arm),
      .push      (|drain_now),
      .push_data (drain_rec),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign log_valid = !fifo_empty;
   assign fifo_pop  = log_valid && log_ready;
   assign log_data  = log_valid ? fifo_head : '0;

endmodule
